// File: rtl/cr_xp10_decomp_be_ob_arb_pkg.sv
// XP10 decompressor back-end shared types.
// TLV bus word and arbiter source encoding.
package cr_xp10_decompPKG;

  typedef enum logic {
    BE_ARB_PT = 1'b0,
    BE_ARB_LZ = 1'b1
  } be_arb_src_e;

  typedef struct packed {
    logic        sot;
    logic        eot;
    logic        tlast;
    logic [7:0]  tuser;
    logic [1:0]  bip2;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

  function automatic logic tlv_release(
    input tlvp_if_bus_t w,
    input bit           on_tlast
  );
    return on_tlast ? w.tlast : w.eot;
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_be_ob_reg.sv
// Single-entry valid/ready output register.
// space is high when a new word may be pushed this cycle.
module cr_xp10_decomp_be_ob_reg
  import cr_xp10_decompPKG::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  tlvp_if_bus_t din,
  input  logic         ready,
  output logic         valid,
  output tlvp_if_bus_t dout,
  output logic         space
);

  assign space = !valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cr_xp10_decomp_be_ob_arb.sv
// Back-end output arbiter: merges PT and LZ TLV streams,
// round-robin with TLV- or frame-atomic grants.
module cr_xp10_decomp_be_ob_arb
  import cr_xp10_decompPKG::*;
#(
  parameter bit LOCK_ON_TLAST = 1'b0,
  parameter int MAX_STALL     = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_ob_empty,
  input  tlvp_if_bus_t pt_ob_tlv,
  output logic         pt_ob_rd,
  input  logic         lz_ob_empty,
  input  tlvp_if_bus_t lz_ob_tlv,
  output logic         lz_ob_rd,
  input  logic         ob_ready,
  output logic         ob_valid,
  output tlvp_if_bus_t ob_tlv,
  output logic         arb_owner,
  output logic         arb_sot_err,
  output logic         stall_err
);

  localparam int CW = $clog2(MAX_STALL) + 1;
  localparam logic [CW-1:0] STALL_MAX = CW'(MAX_STALL);

  logic         locked;
  be_arb_src_e  owner;
  logic [CW-1:0] stall_cnt;
  logic         space;
  logic         pop;
  logic         owner_empty;
  tlvp_if_bus_t pop_tlv;

  assign arb_owner   = owner;
  assign pop         = pt_ob_rd || lz_ob_rd;
  assign pop_tlv     = lz_ob_rd ? lz_ob_tlv : pt_ob_tlv;
  assign owner_empty = (owner == BE_ARB_LZ) ? lz_ob_empty
                                            : pt_ob_empty;

  always_comb begin
    pt_ob_rd = 1'b0;
    lz_ob_rd = 1'b0;
    if (space) begin
      if (locked) begin
        pt_ob_rd = (owner == BE_ARB_PT) && !pt_ob_empty;
        lz_ob_rd = (owner == BE_ARB_LZ) && !lz_ob_empty;
      end else if (!pt_ob_empty && !lz_ob_empty) begin
        pt_ob_rd = (owner == BE_ARB_LZ);
        lz_ob_rd = (owner == BE_ARB_PT);
      end else begin
        pt_ob_rd = !pt_ob_empty;
        lz_ob_rd = !lz_ob_empty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked      <= 1'b0;
      owner       <= BE_ARB_LZ;
      stall_cnt   <= '0;
      arb_sot_err <= 1'b0;
      stall_err   <= 1'b0;
    end else begin
      arb_sot_err <= pop && !locked && !pop_tlv.sot;
      stall_err   <= 1'b0;
      if (pop) begin
        owner  <= be_arb_src_e'(lz_ob_rd);
        locked <= !tlv_release(pop_tlv, LOCK_ON_TLAST);
      end
      // Saturating count; the pulse fires on the single step into MAX.
      if (pop || !locked) begin
        stall_cnt <= '0;
      end else if (owner_empty && stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + CW'(1);
        stall_err <= (stall_cnt == STALL_MAX - CW'(1));
      end
    end
  end

  cr_xp10_decomp_be_ob_reg u_ob_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pop),
    .din   (pop_tlv),
    .ready (ob_ready),
    .valid (ob_valid),
    .dout  (ob_tlv),
    .space (space)
  );

endmodule

// File: tb/tb_cr_xp10_decomp_be_ob_arb.sv
// Bench for the back-end output arbiter: two instances
// (eot-release and tlast-release) driven by one stimulus.
module tb_cr_xp10_decomp_be_ob_arb;
  import cr_xp10_decompPKG::*;

  localparam int MS = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic pt_empty[2], lz_empty[2], pt_rd[2], lz_rd[2];
  logic ob_valid[2], owner[2], sot_err[2], stall_err[2];
  tlvp_if_bus_t pt_tlv[2], lz_tlv[2], ob_tlv[2];

  always #5 clk = ~clk;

  cr_xp10_decomp_be_ob_arb #(.LOCK_ON_TLAST(1'b0), .MAX_STALL(MS)) u0 (
    .clk(clk), .rst_n(rst_n),
    .pt_ob_empty(pt_empty[0]), .pt_ob_tlv(pt_tlv[0]), .pt_ob_rd(pt_rd[0]),
    .lz_ob_empty(lz_empty[0]), .lz_ob_tlv(lz_tlv[0]), .lz_ob_rd(lz_rd[0]),
    .ob_ready(rdy), .ob_valid(ob_valid[0]), .ob_tlv(ob_tlv[0]),
    .arb_owner(owner[0]), .arb_sot_err(sot_err[0]),
    .stall_err(stall_err[0])
  );

  cr_xp10_decomp_be_ob_arb #(.LOCK_ON_TLAST(1'b1), .MAX_STALL(MS)) u1 (
    .clk(clk), .rst_n(rst_n),
    .pt_ob_empty(pt_empty[1]), .pt_ob_tlv(pt_tlv[1]), .pt_ob_rd(pt_rd[1]),
    .lz_ob_empty(lz_empty[1]), .lz_ob_tlv(lz_tlv[1]), .lz_ob_rd(lz_rd[1]),
    .ob_ready(rdy), .ob_valid(ob_valid[1]), .ob_tlv(ob_tlv[1]),
    .arb_owner(owner[1]), .arb_sot_err(sot_err[1]),
    .stall_err(stall_err[1])
  );

  tlvp_if_bus_t pt_q[2][$];
  tlvp_if_bus_t lz_q[2][$];

  bit m_valid[2], m_owner[2], m_locked[2], m_sot[2], m_stall[2];
  int m_cnt[2];
  tlvp_if_bus_t m_word[2];
  bit e_pt[2], e_lz[2];
  string pops[2], outs[2];
  int n_stall[2], n_sot[2];
  int n_checks, n_fail;

  task automatic chk(string nm, int i, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic chk_s(string nm, int i, string act, string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got '%s' expected '%s'", nm, i, act, exp);
    end
  endtask

  function automatic tlvp_if_bus_t mk(bit lz, int n, bit s, bit e, bit t);
    tlvp_if_bus_t w;
    w.sot   = s;
    w.eot   = e;
    w.tlast = t;
    w.tuser = 8'(n * 3);
    w.bip2  = 2'(n);
    w.tdata = {48'h5a5a_0000_0000, (lz ? 8'hb0 : 8'ha0), 8'(n)};
    return w;
  endfunction

  task automatic ld_pt(tlvp_if_bus_t w);
    for (int i = 0; i < 2; i++) pt_q[i].push_back(w);
  endtask

  task automatic ld_lz(tlvp_if_bus_t w);
    for (int i = 0; i < 2; i++) lz_q[i].push_back(w);
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_owner[i] = 1; m_locked[i] = 0;
      m_sot[i] = 0; m_stall[i] = 0; m_cnt[i] = 0; m_word[i] = '0;
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      pops[i] = ""; outs[i] = ""; n_stall[i] = 0; n_sot[i] = 0;
    end
  endtask

  // Model: what must happen this cycle, derived from queue contents.
  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      bit sp, pe, le;
      sp = !m_valid[i] || rdy;
      pe = pt_q[i].size() != 0;
      le = lz_q[i].size() != 0;
      e_pt[i] = 0;
      e_lz[i] = 0;
      if (rst_n && sp) begin
        if (m_locked[i]) begin
          if (m_owner[i]) e_lz[i] = le; else e_pt[i] = pe;
        end else if (pe && le) begin
          if (m_owner[i]) e_pt[i] = 1; else e_lz[i] = 1;
        end else begin
          e_pt[i] = pe;
          e_lz[i] = le;
        end
      end
      chk("pt_ob_rd", i, 128'(pt_rd[i]), 128'(e_pt[i]));
      chk("lz_ob_rd", i, 128'(lz_rd[i]), 128'(e_lz[i]));
      chk("ob_valid", i, 128'(ob_valid[i]), 128'(m_valid[i]));
      if (m_valid[i])
        chk("ob_tlv", i, 128'(ob_tlv[i]), 128'(m_word[i]));
      chk("arb_owner", i, 128'(owner[i]), 128'(m_owner[i]));
      chk("arb_sot_err", i, 128'(sot_err[i]), 128'(m_sot[i]));
      chk("stall_err", i, 128'(stall_err[i]), 128'(m_stall[i]));
      if (ob_valid[i] && rdy)
        outs[i] = {outs[i], $sformatf("%h ", ob_tlv[i].tdata[15:0])};
      if (sot_err[i]) n_stall[i] = n_stall[i];
      if (sot_err[i]) n_sot[i]++;
      if (stall_err[i]) n_stall[i]++;
    end
  endtask

  task automatic update();
    for (int i = 0; i < 2; i++) begin
      bit pop, oe, rel;
      tlvp_if_bus_t w;
      if (!rst_n) begin
        mreset();
        continue;
      end
      pop = e_pt[i] || e_lz[i];
      w = '0;
      if (e_lz[i]) w = lz_q[i][0];
      else if (e_pt[i]) w = pt_q[i][0];
      oe = m_owner[i] ? (lz_q[i].size() == 0) : (pt_q[i].size() == 0);
      m_sot[i] = pop && !m_locked[i] && !w.sot;
      m_stall[i] = 0;
      if (!m_locked[i] || pop) begin
        m_cnt[i] = 0;
      end else if (oe && m_cnt[i] < MS) begin
        m_cnt[i]++;
        m_stall[i] = (m_cnt[i] == MS);
      end
      if (pop) begin
        rel = (i == 1) ? w.tlast : w.eot;
        m_owner[i]  = e_lz[i];
        m_locked[i] = !rel;
        m_valid[i]  = 1;
        m_word[i]   = w;
        pops[i] = {pops[i], e_lz[i] ? "L" : "P"};
        if (e_lz[i]) void'(lz_q[i].pop_front());
        else void'(pt_q[i].pop_front());
      end else if (m_valid[i] && rdy) begin
        m_valid[i] = 0;
      end
    end
  endtask

  task automatic step(bit r);
    @(negedge clk);
    rdy = r;
    for (int i = 0; i < 2; i++) begin
      pt_empty[i] = pt_q[i].size() == 0;
      lz_empty[i] = lz_q[i].size() == 0;
      pt_tlv[i] = pt_empty[i] ? '0 : pt_q[i][0];
      lz_tlv[i] = lz_empty[i] ? '0 : lz_q[i][0];
    end
    #1 check_cycle();
    @(posedge clk);
    update();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      pt_q[i].delete();
      lz_q[i].delete();
    end
    #2 rst_n = 1'b0;
    mreset();
    step(1);
    step(1);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rdy = 1'b1;
    rst_n = 1'b0;
    clr();
    do_reset();

    // single PT TLV of three words
    clr();
    ld_pt(mk(0, 1, 1, 0, 0));
    ld_pt(mk(0, 2, 0, 0, 0));
    ld_pt(mk(0, 3, 0, 1, 1));
    repeat (6) step(1);
    for (int i = 0; i < 2; i++) begin
      chk_s("t1_pops", i, pops[i], "PPP");
      chk_s("t1_outs", i, outs[i], "a001 a002 a003 ");
      chk("t1_owner", i, 128'(owner[i]), 128'(0));
    end

    // round-robin from reset
    do_reset();
    clr();
    ld_pt(mk(0, 1, 1, 0, 0));
    ld_pt(mk(0, 2, 0, 1, 0));
    ld_pt(mk(0, 3, 1, 0, 0));
    ld_pt(mk(0, 4, 0, 1, 1));
    ld_lz(mk(1, 1, 1, 0, 0));
    ld_lz(mk(1, 2, 0, 1, 1));
    repeat (9) step(1);
    chk_s("t2_pops", 0, pops[0], "PPLLPP");
    chk_s("t2_pops", 1, pops[1], "PPPPLL");
    chk_s("t2_outs", 0, outs[0], "a001 a002 b001 b002 a003 a004 ");

    // LZ holds the grant while its FIFO runs dry
    clr();
    ld_lz(mk(1, 1, 1, 0, 0));
    step(1);
    ld_pt(mk(0, 1, 1, 0, 0));
    ld_pt(mk(0, 2, 0, 1, 1));
    repeat (5) step(1);
    ld_lz(mk(1, 2, 0, 1, 1));
    repeat (6) step(1);
    for (int i = 0; i < 2; i++) begin
      chk_s("t3_pops", i, pops[i], "LLPP");
      chk_s("t3_outs", i, outs[i], "b001 b002 a001 a002 ");
    end

    // downstream backpressure
    clr();
    for (int n = 1; n <= 4; n++) ld_pt(mk(0, n, n == 1, n == 4, n == 4));
    step(1);
    step(1);
    repeat (4) step(0);
    repeat (6) step(1);
    for (int i = 0; i < 2; i++) begin
      chk_s("t4_pops", i, pops[i], "PPPP");
      chk_s("t4_outs", i, outs[i], "a001 a002 a003 a004 ");
    end

    // data TLV then footer TLV
    clr();
    ld_lz(mk(1, 1, 1, 0, 0));
    ld_lz(mk(1, 2, 0, 1, 0));
    ld_lz(mk(1, 3, 1, 1, 1));
    ld_pt(mk(0, 1, 1, 0, 0));
    ld_pt(mk(0, 2, 0, 1, 1));
    repeat (8) step(1);
    chk_s("t5_pops", 0, pops[0], "LLPPL");
    chk_s("t5_pops", 1, pops[1], "LLLPP");

    // stall watchdog, then a headless word
    clr();
    ld_lz(mk(1, 1, 1, 0, 0));
    repeat (13) step(1);
    ld_lz(mk(1, 2, 0, 1, 1));
    step(1);
    ld_pt(mk(0, 7, 0, 1, 1));
    repeat (4) step(1);
    for (int i = 0; i < 2; i++) begin
      chk_s("t6_pops", i, pops[i], "LLP");
      chk("t6_stall_pulses", i, 128'(n_stall[i]), 128'(1));
      chk("t6_sot_pulses", i, 128'(n_sot[i]), 128'(1));
      chk_s("t6_outs", i, outs[i], "b001 b002 a007 ");
    end

    // reset in the middle of a TLV
    clr();
    ld_pt(mk(0, 1, 1, 0, 0));
    ld_pt(mk(0, 2, 0, 0, 0));
    step(1);
    do_reset();
    clr();
    ld_pt(mk(0, 5, 1, 1, 1));
    ld_lz(mk(1, 5, 1, 1, 1));
    repeat (4) step(1);
    for (int i = 0; i < 2; i++) begin
      chk_s("t7_pops", i, pops[i], "PL");
      chk_s("t7_outs", i, outs[i], "a005 b005 ");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
